// File: rtl/sram_1rw_init_array_pkg.sv
// sram_pkg: shared types and elaboration helpers for sram_1rw_init_array.
//   state_e       controller states: CLEAR (init sweep) and IDLE (serving requests)
//   clog2_min1    address width helper, never returns less than 1
//   params_legal  parameter legality check (DEPTH >= 2, WIDTH a multiple of MASK_GRAN)
package sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit params_legal(input int depth, input int width, input int gran);
    return (depth >= 2) && (width > 0) && (gran > 0) && ((width % gran) == 0);
  endfunction

endpackage

// File: rtl/sram_1rw_init_array_if.sv
// sram_1rw_init_array_if: request/response bundle of the 1RW self-initialising SRAM.
//   io_clear        restart the clear sweep (pulse)
//   io_req_valid    request present
//   io_req_ready    block accepts the request this cycle
//   io_req_wmode    1 = write, 0 = read
//   io_req_addr     entry index (AW bits)
//   io_req_wmask    per-segment write enable (SEGS bits)
//   io_req_wdata    write data (WIDTH bits)
//   io_resp_valid   one-cycle pulse per read response
//   io_resp_rdata   read data, held until the next read response
//   io_init_done    clear sweep complete
// master = requester side, slave = the SRAM block.
interface sram_1rw_init_array_if #(
  parameter int AW    = 6,
  parameter int WIDTH = 6,
  parameter int SEGS  = 1
);

  logic             io_clear;
  logic             io_req_valid;
  logic             io_req_ready;
  logic             io_req_wmode;
  logic [AW-1:0]    io_req_addr;
  logic [SEGS-1:0]  io_req_wmask;
  logic [WIDTH-1:0] io_req_wdata;
  logic             io_resp_valid;
  logic [WIDTH-1:0] io_resp_rdata;
  logic             io_init_done;

  modport master (
    output io_clear, io_req_valid, io_req_wmode, io_req_addr, io_req_wmask, io_req_wdata,
    input  io_req_ready, io_resp_valid, io_resp_rdata, io_init_done
  );

  modport slave (
    input  io_clear, io_req_valid, io_req_wmode, io_req_addr, io_req_wmask, io_req_wdata,
    output io_req_ready, io_resp_valid, io_resp_rdata, io_init_done
  );

endinterface

// File: rtl/sram_1rw_init_array_core.sv
// sram_1rw_core: raw DEPTH x WIDTH single-port array with segment write mask.
//   clock   rising-edge clock
//   en      access enable (caller guarantees addr < DEPTH when en=1)
//   wmode   1 = masked write, 0 = read
//   addr    entry index
//   wmask   per-segment write enable, MASK_GRAN bits per segment
//   wdata   write data
//   rdata   contents of the entry addressed by the last read (registered address)
// No reset: contents are established by the controller's clear sweep.
module sram_1rw_core #(
  parameter int DEPTH     = 64,
  parameter int WIDTH     = 6,
  parameter int MASK_GRAN = 6,
  parameter int AW        = 6
) (
  input  logic                         clock,
  input  logic                         en,
  input  logic                         wmode,
  input  logic [AW-1:0]                addr,
  input  logic [WIDTH/MASK_GRAN-1:0]   wmask,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata
);

  localparam int SEGS = WIDTH / MASK_GRAN;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    raddr_q;
  logic [AW-1:0]    raddr_d;

  // The read address is only captured on a read so the output follows the
  // most recently read entry.
  always_comb begin
    raddr_d = raddr_q;
    if (en && !wmode) raddr_d = addr;
  end

  always_ff @(posedge clock) begin
    raddr_q <= raddr_d;
    if (en && wmode) begin
      for (int s = 0; s < SEGS; s++) begin
        if (wmask[s]) mem_q[addr][s*MASK_GRAN +: MASK_GRAN] <= wdata[s*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  assign rdata = mem_q[raddr_q];

endmodule

// File: rtl/sram_1rw_init_array.sv
// sram_1rw_init_array: parametrised 1RW masked SRAM with a clear sweep after
// reset (and on io_clear), valid/ready request port and held read data.
//   clock  rising-edge clock
//   reset  asynchronous, active-high
//   io     sram_1rw_init_array_if.slave (request, response, io_clear, io_init_done)
// Parameters: DEPTH (>= 2, any value), WIDTH, MASK_GRAN (divides WIDTH), INIT_VAL.
// Build option: define SRAM_OUTPUT_REG_EN to add an output register stage
// (read latency 2 instead of 1, same throughput).
module sram_1rw_init_array
  import sram_pkg::*;
#(
  parameter int               DEPTH     = 64,
  parameter int               WIDTH     = 6,
  parameter int               MASK_GRAN = 6,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  sram_1rw_init_array_if.slave  io
);

  localparam int AW   = clog2_min1(DEPTH);
  localparam int SEGS = WIDTH / MASK_GRAN;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  if (!params_legal(DEPTH, WIDTH, MASK_GRAN)) begin : g_param_err
    $error("sram_1rw_init_array: DEPTH must be >= 2 and WIDTH a multiple of MASK_GRAN");
  end

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_oob_q, rd_oob_d;

  logic             core_en;
  logic             core_wmode;
  logic [AW-1:0]    core_addr;
  logic [SEGS-1:0]  core_wmask;
  logic [WIDTH-1:0] core_wdata;
  logic [WIDTH-1:0] core_rdata;

  logic             fire;
  logic             addr_in_range;
  logic [WIDTH-1:0] read_val;

  // Only relevant when DEPTH is not a power of two; out-of-range requests
  // never reach the array.
  assign addr_in_range = ({1'b0, io.io_req_addr} < (AW+1)'(DEPTH));

  // Controller: CLEAR owns the array port and writes INIT_VAL one entry per
  // cycle; IDLE hands the port to the requester. io_clear wins over a request
  // in the same cycle by dropping ready.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    rd_pend_d       = 1'b0;
    rd_oob_d        = 1'b0;
    fire            = 1'b0;
    core_en         = 1'b0;
    core_wmode      = 1'b0;
    core_addr       = io.io_req_addr;
    core_wmask      = io.io_req_wmask;
    core_wdata      = io.io_req_wdata;
    io.io_req_ready = 1'b0;
    io.io_init_done = 1'b0;
    case (state_q)
      CLEAR: begin
        core_en    = 1'b1;
        core_wmode = 1'b1;
        core_addr  = ptr_q;
        core_wmask = '1;
        core_wdata = INIT_VAL;
        if (ptr_q == LAST_PTR) begin
          ptr_d   = '0;
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      IDLE: begin
        io.io_init_done = 1'b1;
        if (io.io_clear) begin
          ptr_d   = '0;
          state_d = CLEAR;
        end else begin
          io.io_req_ready = 1'b1;
          fire            = io.io_req_valid;
          if (fire) begin
            core_en    = addr_in_range;
            core_wmode = io.io_req_wmode;
            rd_pend_d  = !io.io_req_wmode;
            rd_oob_d   = !addr_in_range;
          end
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_oob_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_oob_q  <= rd_oob_d;
    end
  end

  sram_1rw_core #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .MASK_GRAN (MASK_GRAN),
    .AW        (AW)
  ) u_core (
    .clock (clock),
    .en    (core_en),
    .wmode (core_wmode),
    .addr  (core_addr),
    .wmask (core_wmask),
    .wdata (core_wdata),
    .rdata (core_rdata)
  );

  // Out-of-range reads answer with INIT_VAL without touching the array.
  assign read_val = rd_oob_q ? INIT_VAL : core_rdata;

`ifdef SRAM_OUTPUT_REG_EN
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  // Extra stage after the array; it is flushed when a new sweep starts so a
  // response in flight across io_clear is dropped.
  always_comb begin
    out_valid_d = rd_pend_q;
    out_data_d  = rd_pend_q ? read_val : out_data_q;
    if (state_q == IDLE && state_d == CLEAR) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign io.io_resp_valid = out_valid_q && (state_q == IDLE);
  assign io.io_resp_rdata = out_data_q;
`else
  logic [WIDTH-1:0] hold_q, hold_d;

  // The response is presented straight from the array; the hold register
  // keeps it visible after the valid pulse, unaffected by later writes.
  always_comb begin
    hold_d = rd_pend_q ? read_val : hold_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end

  assign io.io_resp_valid = rd_pend_q && (state_q == IDLE);
  assign io.io_resp_rdata = rd_pend_q ? read_val : hold_q;
`endif

endmodule

// File: tb/tb_sram_1rw_init_array.sv
// tb_sram_1rw_init_array: two instances of sram_1rw_init_array.
//   dutA: DEPTH=64, WIDTH=6, MASK_GRAN=6, INIT_VAL=0
//   dutB: DEPTH=48, WIDTH=8, MASK_GRAN=4, INIT_VAL=8'h5A (non-power-of-two depth, two segments)
// Read expectations come from a behavioural array model and are queued with
// the cycle in which the response must appear.
module tb_sram_1rw_init_array;

`ifdef SRAM_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clock;
  logic resetA;
  logic resetB;
  int   cyc;
  int   checkCount;
  int   errCount;

  logic [7:0] memA [64];
  logic [7:0] memB [48];
  exp_t       qA [$];
  exp_t       qB [$];
  exp_t       eA;
  exp_t       eB;

  sram_1rw_init_array_if #(.AW(6), .WIDTH(6), .SEGS(1)) ifA ();
  sram_1rw_init_array_if #(.AW(6), .WIDTH(8), .SEGS(2)) ifB ();

  sram_1rw_init_array #(
    .DEPTH(64), .WIDTH(6), .MASK_GRAN(6), .INIT_VAL(6'h00)
  ) dutA (
    .clock (clock),
    .reset (resetA),
    .io    (ifA)
  );

  sram_1rw_init_array #(
    .DEPTH(48), .WIDTH(8), .MASK_GRAN(4), .INIT_VAL(8'h5A)
  ) dutB (
    .clock (clock),
    .reset (resetB),
    .io    (ifB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] merge(input logic [7:0] old, input logic [7:0] nw,
                                       input logic [1:0] mask, input int gran, input int width);
    logic [7:0] r;
    r = old;
    for (int b = 0; b < width; b++) begin
      if (mask[b/gran]) r[b] = nw[b];
    end
    return r;
  endfunction

  task automatic modelInit(input int dut);
    if (dut == 0) begin
      for (int i = 0; i < 64; i++) memA[i] = 8'h00;
    end else begin
      for (int i = 0; i < 48; i++) memB[i] = 8'h5A;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drives one request for one cycle (called #1 after a rising edge), updates
  // the model and queues the expected read response.
  task automatic applyStimulus(input int dut, input bit wmode, input int addr,
                               input logic [1:0] mask, input logic [7:0] data);
    exp_t e;
    if (dut == 0) begin
      ifA.io_req_valid = 1'b1;
      ifA.io_req_wmode = wmode;
      ifA.io_req_addr  = 6'(addr);
      ifA.io_req_wmask = mask[0:0];
      ifA.io_req_wdata = data[5:0];
      checkOutput("A_ready", ifA.io_req_ready, 1);
      if (wmode) begin
        if (addr < 64) memA[addr] = merge(memA[addr], data, mask, 6, 6);
      end else begin
        e.data = (addr < 64) ? memA[addr] : 8'h00;
        e.cyc  = cyc + LAT;
        qA.push_back(e);
      end
    end else begin
      ifB.io_req_valid = 1'b1;
      ifB.io_req_wmode = wmode;
      ifB.io_req_addr  = 6'(addr);
      ifB.io_req_wmask = mask;
      ifB.io_req_wdata = data;
      checkOutput("B_ready", ifB.io_req_ready, 1);
      if (wmode) begin
        if (addr < 48) memB[addr] = merge(memB[addr], data, mask, 4, 8);
      end else begin
        e.data = (addr < 48) ? memB[addr] : 8'h5A;
        e.cyc  = cyc + LAT;
        qB.push_back(e);
      end
    end
    @(posedge clock);
    #1;
    ifA.io_req_valid = 1'b0;
    ifB.io_req_valid = 1'b0;
  endtask

  // Response scoreboard: every response must match the oldest queued read,
  // arrive in its expected cycle, and nothing may arrive unasked.
  always @(negedge clock) begin
    if (ifA.io_resp_valid) begin
      if (qA.size() == 0) begin
        checkOutput("A_unexpected_resp", ifA.io_resp_valid, 0);
      end else begin
        eA = qA.pop_front();
        checkOutput("A_rdata", ifA.io_resp_rdata, eA.data);
        checkOutput("A_resp_cycle", cyc, eA.cyc);
      end
    end else if (qA.size() > 0 && qA[0].cyc <= cyc) begin
      eA = qA.pop_front();
      checkOutput("A_missing_resp", ifA.io_resp_valid, 1);
    end
    if (ifB.io_resp_valid) begin
      if (qB.size() == 0) begin
        checkOutput("B_unexpected_resp", ifB.io_resp_valid, 0);
      end else begin
        eB = qB.pop_front();
        checkOutput("B_rdata", ifB.io_resp_rdata, eB.data);
        checkOutput("B_resp_cycle", cyc, eB.cyc);
      end
    end else if (qB.size() > 0 && qB[0].cyc <= cyc) begin
      eB = qB.pop_front();
      checkOutput("B_missing_resp", ifB.io_resp_valid, 1);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errCount, checkCount);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int nA;
    int nB;
    cyc        = 0;
    checkCount = 0;
    errCount   = 0;
    resetA     = 1'b0;
    resetB     = 1'b0;
    ifA.io_clear = 1'b0; ifA.io_req_valid = 1'b0; ifA.io_req_wmode = 1'b0;
    ifA.io_req_addr = '0; ifA.io_req_wmask = '0; ifA.io_req_wdata = '0;
    ifB.io_clear = 1'b0; ifB.io_req_valid = 1'b0; ifB.io_req_wmode = 1'b0;
    ifB.io_req_addr = '0; ifB.io_req_wmask = '0; ifB.io_req_wdata = '0;
    #1;
    resetA = 1'b1;
    resetB = 1'b1;
    #1;
    checkOutput("A_rst_ready", ifA.io_req_ready, 0);
    checkOutput("A_rst_resp_valid", ifA.io_resp_valid, 0);
    checkOutput("A_rst_rdata", ifA.io_resp_rdata, 0);
    checkOutput("A_rst_init_done", ifA.io_init_done, 0);
    checkOutput("B_rst_ready", ifB.io_req_ready, 0);
    checkOutput("B_rst_init_done", ifB.io_init_done, 0);
    checkOutput("B_rst_rdata", ifB.io_resp_rdata, 0);

    repeat (3) @(posedge clock);
    #1;
    resetA = 1'b0;
    resetB = 1'b0;
    modelInit(0);
    modelInit(1);

    // Sweep length: init_done must first be seen after exactly DEPTH edges.
    nA = 0;
    nB = 0;
    for (int n = 1; n <= 120; n++) begin
      @(posedge clock);
      #1;
      if (ifA.io_init_done && nA == 0) nA = n;
      if (ifB.io_init_done && nB == 0) nB = n;
      if (nA != 0 && nB != 0) break;
    end
    checkOutput("A_sweep_cycles", nA, 64);
    checkOutput("B_sweep_cycles", nB, 48);

    // Every entry of A reads back INIT_VAL, back to back.
    for (int i = 0; i < 64; i++) applyStimulus(0, 1'b0, i, 2'b00, 8'h00);
    idle(3);

    // Write then read; later write to the same entry must not disturb held data.
    applyStimulus(0, 1'b1, 5, 2'b01, 8'h2A);
    applyStimulus(0, 1'b0, 5, 2'b00, 8'h00);
    idle(3);
    applyStimulus(0, 1'b1, 5, 2'b01, 8'h15);
    idle(3);
    @(negedge clock);
    checkOutput("A_hold_rdata", ifA.io_resp_rdata, 8'h2A);
    checkOutput("A_hold_valid", ifA.io_resp_valid, 0);
    @(posedge clock);
    #1;
    applyStimulus(0, 1'b0, 5, 2'b00, 8'h00);
    idle(3);

    // io_clear with a simultaneous read: not accepted, sweep restarts.
    applyStimulus(0, 1'b1, 9, 2'b01, 8'h3F);
    idle(2);
    ifA.io_clear     = 1'b1;
    ifA.io_req_valid = 1'b1;
    ifA.io_req_wmode = 1'b0;
    ifA.io_req_addr  = 6'd9;
    #1;
    checkOutput("A_ready_with_clear", ifA.io_req_ready, 0);
    checkOutput("A_done_before_clear", ifA.io_init_done, 1);
    @(posedge clock);
    #1;
    ifA.io_clear     = 1'b0;
    ifA.io_req_valid = 1'b0;
    checkOutput("A_done_after_clear", ifA.io_init_done, 0);
    modelInit(0);
    nA = 0;
    for (int n = 1; n <= 120; n++) begin
      @(posedge clock);
      #1;
      if (ifA.io_init_done) begin
        nA = n;
        break;
      end
    end
    checkOutput("A_clear_sweep_cycles", nA, 64);
    applyStimulus(0, 1'b0, 9, 2'b00, 8'h00);
    applyStimulus(0, 1'b0, 5, 2'b00, 8'h00);
    applyStimulus(0, 1'b0, 63, 2'b00, 8'h00);
    idle(3);

    // B: segment masking, out-of-range address, last entry, back-to-back reads.
    applyStimulus(1, 1'b1, 3, 2'b11, 8'hFF);
    applyStimulus(1, 1'b1, 3, 2'b01, 8'h00);
    applyStimulus(1, 1'b0, 3, 2'b00, 8'h00);
    applyStimulus(1, 1'b1, 50, 2'b11, 8'h33);
    applyStimulus(1, 1'b0, 50, 2'b00, 8'h00);
    applyStimulus(1, 1'b0, 47, 2'b00, 8'h00);
    applyStimulus(1, 1'b1, 47, 2'b10, 8'hC3);
    applyStimulus(1, 1'b0, 47, 2'b00, 8'h00);
    applyStimulus(1, 1'b0, 3, 2'b00, 8'h00);
    applyStimulus(1, 1'b0, 50, 2'b00, 8'h00);
    idle(4);

    // B: reset in the middle of a sweep.
    resetB = 1'b1;
    #1;
    checkOutput("B_rst2_rdata", ifB.io_resp_rdata, 0);
    checkOutput("B_rst2_init_done", ifB.io_init_done, 0);
    @(posedge clock);
    #1;
    resetB = 1'b0;
    modelInit(1);
    idle(20);
    checkOutput("B_mid_sweep_done", ifB.io_init_done, 0);
    resetB = 1'b1;
    #1;
    checkOutput("B_rst3_ready", ifB.io_req_ready, 0);
    checkOutput("B_rst3_resp_valid", ifB.io_resp_valid, 0);
    @(posedge clock);
    #1;
    resetB = 1'b0;
    nB = 0;
    for (int n = 1; n <= 120; n++) begin
      @(posedge clock);
      #1;
      if (ifB.io_init_done) begin
        nB = n;
        break;
      end
    end
    checkOutput("B_resweep_cycles", nB, 48);
    applyStimulus(1, 1'b0, 3, 2'b00, 8'h00);
    applyStimulus(1, 1'b0, 47, 2'b00, 8'h00);
    idle(4);

    checkOutput("A_queue_drained", qA.size(), 0);
    checkOutput("B_queue_drained", qB.size(), 0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
